// File: rtl/wb_master_seq.sv
// Wishbone classic initiator: turns each command into 1..2^LEN_W single-beat
// transfers at incrementing word addresses, one response per beat, with a
// per-beat ack timeout that abandons the rest of the command.
module wb_master_seq #(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int LEN_W     = 4,
    parameter int TO_CYCLES = 255
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_n_i,
    // command stream
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic            cmd_we,
    input  logic [AW-1:0]   cmd_adr,
    input  logic [DW/8-1:0] cmd_sel,
    input  logic [LEN_W-1:0] cmd_len,
    // write data stream
    input  logic            wdat_valid,
    output logic            wdat_ready,
    input  logic [DW-1:0]   wdat,
    // response stream
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [DW-1:0]   rsp_dat,
    output logic            rsp_err,
    output logic            rsp_last,
    // Wishbone initiator
    output logic            wbm_cyc_o,
    output logic            wbm_stb_o,
    output logic            wbm_we_o,
    output logic [DW/8-1:0] wbm_sel_o,
    output logic [AW-1:0]   wbm_adr_o,
    output logic [DW-1:0]   wbm_dat_o,
    input  logic            wbm_ack_i,
    input  logic [DW-1:0]   wbm_dat_i,
    output logic            busy
);

    localparam int SW   = DW / 8;
    localparam int TO_W = $clog2(TO_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, FETCH, BUS, RESP} state_t;

    state_t            state_q, state_d;
    logic              we_q, we_d;
    logic [AW-1:0]     adr_q, adr_d;
    logic [SW-1:0]     sel_q, sel_d;
    logic [DW-1:0]     wdat_q, wdat_d;
    logic [DW-1:0]     rdat_q, rdat_d;
    logic [LEN_W-1:0]  beats_q, beats_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic              err_q, err_d;
    logic              first_q, first_d;   // still on beat 0 of the command
    logic              last_w;

    // A timed-out beat is always the final response: remaining beats are dropped.
    assign last_w = (beats_q == '0) || err_q;

    // State and datapath registers; reset aborts any burst without a response.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_q  <= IDLE;
            we_q     <= 1'b0;
            adr_q    <= '0;
            sel_q    <= '0;
            wdat_q   <= '0;
            rdat_q   <= '0;
            beats_q  <= '0;
            to_cnt_q <= '0;
            err_q    <= 1'b0;
            first_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            adr_q    <= adr_d;
            sel_q    <= sel_d;
            wdat_q   <= wdat_d;
            rdat_q   <= rdat_d;
            beats_q  <= beats_d;
            to_cnt_q <= to_cnt_d;
            err_q    <= err_d;
            first_q  <= first_d;
        end
    end

    // Next-state and datapath updates.
    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        adr_d    = adr_q;
        sel_d    = sel_q;
        wdat_d   = wdat_q;
        rdat_d   = rdat_q;
        beats_d  = beats_q;
        to_cnt_d = to_cnt_q;
        err_d    = err_q;
        first_d  = first_q;
        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    we_d     = cmd_we;
                    adr_d    = cmd_adr;
                    sel_d    = cmd_sel;
                    beats_d  = cmd_len;
                    to_cnt_d = '0;
                    err_d    = 1'b0;
                    first_d  = 1'b1;
                    state_d  = cmd_we ? FETCH : BUS;
                end
            end
            FETCH: begin
                if (wdat_valid) begin
                    wdat_d  = wdat;
                    state_d = BUS;
                end
            end
            BUS: begin
                // ack wins over a timeout landing in the same cycle
                if (wbm_ack_i) begin
                    rdat_d  = we_q ? '0 : wbm_dat_i;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else if (to_cnt_q == TO_W'(TO_CYCLES)) begin
                    rdat_d  = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    if (last_w) begin
                        state_d = IDLE;
                    end else begin
                        beats_d  = beats_q - 1'b1;
                        adr_d    = adr_q + AW'(SW);
                        to_cnt_d = '0;
                        first_d  = 1'b0;
                        state_d  = we_q ? FETCH : BUS;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Handshake and bus strobes decode straight from the state so reset drops them at once.
    always_comb begin
        cmd_ready  = (state_q == IDLE);
        wdat_ready = (state_q == FETCH);
        rsp_valid  = (state_q == RESP);
        rsp_err    = (state_q == RESP) && err_q;
        rsp_last   = (state_q == RESP) && last_w;
        wbm_stb_o  = (state_q == BUS);
        busy       = (state_q != IDLE);
        unique case (state_q)
            FETCH:   wbm_cyc_o = !first_q;
            BUS:     wbm_cyc_o = 1'b1;
            RESP:    wbm_cyc_o = !last_w;
            default: wbm_cyc_o = 1'b0;
        endcase
    end

    assign rsp_dat   = rdat_q;
    assign wbm_we_o  = we_q;
    assign wbm_sel_o = sel_q;
    assign wbm_adr_o = adr_q;
    assign wbm_dat_o = wdat_q;

endmodule

// File: tb/tb_wb_master_seq.sv
// Directed bench for wb_master_seq: table of commands driven against a
// scripted Wishbone slave, plus hand sequences for stray ack and reset.
module tb_wb_master_seq;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int LEN_W = 4;
    localparam int TO = 255;
    localparam int NONE = 1000;   // ack_dly value meaning "never ack"

    logic             wb_clk_i = 1'b0;
    logic             wb_rst_n_i;
    logic             cmd_valid, cmd_ready, cmd_we;
    logic [AW-1:0]    cmd_adr;
    logic [DW/8-1:0]  cmd_sel;
    logic [LEN_W-1:0] cmd_len;
    logic             wdat_valid, wdat_ready;
    logic [DW-1:0]    wdat;
    logic             rsp_valid, rsp_ready, rsp_err, rsp_last;
    logic [DW-1:0]    rsp_dat;
    logic             wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_ack_i, busy;
    logic [DW/8-1:0]  wbm_sel_o;
    logic [AW-1:0]    wbm_adr_o;
    logic [DW-1:0]    wbm_dat_o, wbm_dat_i;

    int checks = 0;
    int errors = 0;

    wb_master_seq #(.AW(AW), .DW(DW), .LEN_W(LEN_W), .TO_CYCLES(TO)) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_n_i(wb_rst_n_i),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_adr(cmd_adr), .cmd_sel(cmd_sel), .cmd_len(cmd_len),
        .wdat_valid(wdat_valid), .wdat_ready(wdat_ready), .wdat(wdat),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat),
        .rsp_err(rsp_err), .rsp_last(rsp_last),
        .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
        .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
        .wbm_ack_i(wbm_ack_i), .wbm_dat_i(wbm_dat_i), .busy(busy)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    typedef struct {
        logic             we;
        logic [AW-1:0]    adr;
        logic [3:0]       sel;
        logic [LEN_W-1:0] len;
        int               ack_dly;   // stb cycle index (0-based) on which the slave acks
        int               bp;        // cycles rsp_ready is held low per response
        logic [3:0][31:0] data;      // write data / slave read data per beat
        int               nrsp;      // expected number of responses
        logic             err;       // final response expected to be an error
    } vec_t;

    vec_t vecs[7];

    task automatic step();
        @(posedge wb_clk_i);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic do_cmd(input vec_t v);
        int n, nr, exp_n;
        logic last_e;
        logic [31:0] exp_d;
        nr = 0;
        chk("idle_cmd_ready", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1; cmd_we = v.we; cmd_adr = v.adr; cmd_sel = v.sel; cmd_len = v.len;
        step();
        cmd_valid = 1'b0;
        for (int i = 0; i <= int'(v.len); i++) begin
            last_e = (i == v.nrsp - 1);
            if (v.we) begin
                for (int k = 0; k < 4 && !wdat_ready; k++) step();
                chk("fetch_wdat_ready", 32'(wdat_ready), 32'd1);
                chk("fetch_cyc", 32'(wbm_cyc_o), 32'(i > 0));
                chk("fetch_stb", 32'(wbm_stb_o), 32'd0);
                wdat_valid = 1'b1; wdat = v.data[i];
                step();
                wdat_valid = 1'b0; wdat = '0;
            end
            for (int k = 0; k < 4 && !wbm_stb_o; k++) step();
            chk("stb_rise", 32'(wbm_stb_o), 32'd1);
            if (!wbm_stb_o) return;
            chk("bus_cyc", 32'(wbm_cyc_o), 32'd1);
            chk("bus_adr", wbm_adr_o, v.adr + 32'(4 * i));
            chk("bus_we", 32'(wbm_we_o), 32'(v.we));
            chk("bus_sel", 32'(wbm_sel_o), 32'(v.sel));
            if (v.we) chk("bus_wdat", wbm_dat_o, v.data[i]);
            n = 0;
            while (wbm_stb_o && n < 400) begin
                if (n == v.ack_dly) begin
                    wbm_ack_i = 1'b1;
                    wbm_dat_i = v.we ? 32'hBAD0_0BAD : v.data[i];
                end
                step();
                wbm_ack_i = 1'b0;
                n++;
            end
            exp_n = (v.ack_dly > TO) ? TO + 1 : v.ack_dly + 1;
            chk("stb_cycles", 32'(n), 32'(exp_n));
            exp_d = (v.we || (v.err && last_e)) ? 32'd0 : v.data[i];
            chk("rsp_valid", 32'(rsp_valid), 32'd1);
            chk("rsp_dat", rsp_dat, exp_d);
            chk("rsp_err", 32'(rsp_err), 32'(v.err && last_e));
            chk("rsp_last", 32'(rsp_last), 32'(last_e));
            chk("resp_cyc", 32'(wbm_cyc_o), 32'(!last_e));
            // backpressure with stray acks: everything must hold, no new strobe
            for (int b = 0; b < v.bp; b++) begin
                wbm_ack_i = b[0];
                wbm_dat_i = 32'hFFFF_FFFF;
                step();
                wbm_ack_i = 1'b0;
                chk("bp_valid", 32'(rsp_valid), 32'd1);
                chk("bp_dat", rsp_dat, exp_d);
                chk("bp_stb", 32'(wbm_stb_o), 32'd0);
                chk("bp_cyc", 32'(wbm_cyc_o), 32'(!last_e));
            end
            rsp_ready = 1'b1;
            step();
            rsp_ready = 1'b0;
            nr++;
            if (last_e) break;
        end
        chk("rsp_count", 32'(nr), 32'(v.nrsp));
        chk("end_cyc", 32'(wbm_cyc_o), 32'd0);
        chk("end_busy", 32'(busy), 32'd0);
        chk("end_cmd_ready", 32'(cmd_ready), 32'd1);
    endtask

    initial begin
        wb_rst_n_i = 1'b0;
        cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_sel = '0; cmd_len = '0;
        wdat_valid = 1'b0; wdat = '0; rsp_ready = 1'b0;
        wbm_ack_i = 1'b0; wbm_dat_i = '0;

        vecs[0] = '{1'b0, 32'h3000_0000, 4'hF, 4'd0, 2,    0,  {32'h0, 32'h0, 32'h0, 32'hDEAD_BEEF}, 1, 1'b0};
        vecs[1] = '{1'b1, 32'h3000_0010, 4'hF, 4'd3, 0,    0,  {32'h44, 32'h33, 32'h22, 32'h11},     4, 1'b0};
        vecs[2] = '{1'b0, 32'h3000_0100, 4'hF, 4'd2, NONE, 0,  {32'h3, 32'h2, 32'h1, 32'h0},         1, 1'b1};
        vecs[3] = '{1'b0, 32'hFFFF_FFFC, 4'hF, 4'd1, 0,    0,  {32'h0, 32'h0, 32'h5A5A_0002, 32'hA5A5_0001}, 2, 1'b0};
        vecs[4] = '{1'b0, 32'h3000_0200, 4'hF, 4'd0, TO,   0,  {32'h0, 32'h0, 32'h0, 32'hCAFE_F00D}, 1, 1'b0};
        vecs[5] = '{1'b0, 32'h3000_0300, 4'hF, 4'd1, 1,    10, {32'h0, 32'h0, 32'h9ABC_DEF0, 32'h1234_5678}, 2, 1'b0};
        vecs[6] = '{1'b1, 32'h2000_0000, 4'h3, 4'd1, 3,    3,  {32'h0, 32'h0, 32'h0000_BEEF, 32'h0000_F00D}, 2, 1'b0};

        // reset state
        #3;
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_cyc", 32'(wbm_cyc_o), 32'd0);
        chk("rst_stb", 32'(wbm_stb_o), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_wdat_ready", 32'(wdat_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        @(negedge wb_clk_i);
        wb_rst_n_i = 1'b1;
        step();

        // stray ack while idle
        wbm_ack_i = 1'b1;
        step();
        wbm_ack_i = 1'b0;
        chk("stray_idle_stb", 32'(wbm_stb_o), 32'd0);
        chk("stray_idle_busy", 32'(busy), 32'd0);
        chk("stray_idle_rsp", 32'(rsp_valid), 32'd0);

        for (int v = 0; v < 7; v++) do_cmd(vecs[v]);

        // reset during the third beat of a 4-beat read
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 32'h3000_0400; cmd_sel = 4'hF; cmd_len = 4'd3;
        step();
        cmd_valid = 1'b0;
        for (int b = 0; b < 2; b++) begin
            chk("rst_seq_stb", 32'(wbm_stb_o), 32'd1);
            wbm_ack_i = 1'b1; wbm_dat_i = 32'(b);
            step();
            wbm_ack_i = 1'b0;
            chk("rst_seq_rsp", 32'(rsp_valid), 32'd1);
            rsp_ready = 1'b1;
            step();
            rsp_ready = 1'b0;
        end
        chk("rst_seq_beat2_stb", 32'(wbm_stb_o), 32'd1);
        chk("rst_seq_beat2_adr", wbm_adr_o, 32'h3000_0408);
        #2;
        wb_rst_n_i = 1'b0;
        #1;
        chk("async_rst_cyc", 32'(wbm_cyc_o), 32'd0);
        chk("async_rst_stb", 32'(wbm_stb_o), 32'd0);
        chk("async_rst_rsp", 32'(rsp_valid), 32'd0);
        chk("async_rst_cmd_ready", 32'(cmd_ready), 32'd1);
        @(negedge wb_clk_i);
        wb_rst_n_i = 1'b1;
        step();
        do_cmd(vecs[0]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
